// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   master_e    : requester identity (M0 = core LSU, M1 = debug/loader)
//   arb_state_e : arbiter ownership state
//   RD_LAT      : RAM read latency in cycles
package dmem_arb_pkg;

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;

  typedef enum logic {FREE = 1'b0, LOCK1 = 1'b1} arb_state_e;

  localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick, purely combinational.
//   req_i  [1:0] : request vector, bit index = master id
//   last_i       : master granted most recently; loses a tie
//   gnt_o  [1:0] : one-hot grant (or zero when nobody requests)
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_e    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == M1) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core load/store port (M0) and
// the debug/program-loader port (M1). Round-robin with an optional bounded
// lock that lets M1 keep ownership for burst loads. Grant is same-cycle; read
// data returns one cycle later flagged by the issuer's rvalid.
//   clk, reset            : clock, synchronous active-high reset
//   m0_* / m1_*           : requester ports (req, we, addr, wdata, be -> gnt, rvalid)
//   m1_lock               : M1 keeps ownership after this grant
//   rdata                 : shared read data, qualified by mX_rvalid
//   mem_*                 : RAM side (en, we, addr, wdata, be, rdata)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned       CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  LOCK_LIM = CNT_W'(MAX_LOCK);

  arb_state_e       state_q, state_d;
  master_e          rr_last_q, rr_last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             rsp_vld_q, rsp_vld_d;
  master_e          rsp_own_q, rsp_own_d;
  logic [1:0]       rr_gnt;
  logic             gnt0, gnt1;

  arb_rr2 u_rr (
    .req_i  ({m1_req, m0_req}),
    .last_i (rr_last_q),
    .gnt_o  (rr_gnt)
  );

  assign lock_cnt_inc = lock_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    // Grants are forced low during reset so nothing reaches the RAM.
    if (!reset) begin
      if (state_q == FREE) begin
        gnt0 = rr_gnt[0];
        gnt1 = rr_gnt[1];
        // With MAX_LOCK == 1 the first locked grant already exhausts the lock.
        if (gnt1 && m1_lock && (MAX_LOCK > 1)) begin
          state_d    = LOCK1;
          lock_cnt_d = CNT_W'(1);
        end
      end else begin
        gnt1 = m1_req;
        if (!m1_req || !m1_lock || (lock_cnt_inc == LOCK_LIM)) begin
          // Exhaustion leaves rr_last = M1, so a waiting M0 wins next.
          state_d    = FREE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
    end

    if (gnt0) rr_last_d = M0;
    if (gnt1) rr_last_d = M1;

    rsp_vld_d = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    rsp_own_d = gnt1 ? M1 : M0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FREE;
      rr_last_q  <= M1;
      lock_cnt_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= M0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_own_q  <= rsp_own_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt1 ? m1_we    : (gnt0 ? m0_we    : 1'b0);
  assign mem_addr  = gnt1 ? m1_addr  : (gnt0 ? m0_addr  : '0);
  assign mem_wdata = gnt1 ? m1_wdata : (gnt0 ? m0_wdata : '0);
  assign mem_be    = gnt1 ? m1_be    : (gnt0 ? m0_be    : '0);

  assign m0_rvalid = rsp_vld_q && (rsp_own_q == M0) && !reset;
  assign m1_rvalid = rsp_vld_q && (rsp_own_q == M1) && !reset;
  assign rdata     = mem_rdata;

endmodule
